// File: rtl/hs_rr_arbiter_pkg.sv
// Shared handshake definitions: arbiter state encoding, counter width, clog2 helper.
package hs_rr_arbiter_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    // Wide enough for beat_cnt up to MAX_BURST-1 = 14.
    localparam int CNT_W = 4;

    // Ceiling log2, used for the source-index width; returns at least 1.
    function automatic int hs_clog2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/hs_reg_slice.sv
// One-entry output register: holds a beat (data + source tag) until downstream takes it.
module hs_reg_slice #(
    parameter int WORD_WIDTH = 8,
    parameter int SRC_W      = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WORD_WIDTH-1:0] in_data,
    input  logic [SRC_W-1:0]      in_src,
    output logic                  out_valid,
    output logic [WORD_WIDTH-1:0] out_data,
    output logic [SRC_W-1:0]      out_src,
    input  logic                  out_ready
);

    // Accept a new beat whenever the slot is empty or draining this cycle.
    assign in_ready = !out_valid || out_ready;

    // Load on upstream transfer; otherwise drop valid once downstream takes the beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
        end else if (in_valid && in_ready) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
            out_src   <= in_src;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/hs_rr_arbiter.sv
// Round-robin burst arbiter: N_REQ valid/ready requesters muxed onto one registered output.
module hs_rr_arbiter
    import hs_rr_arbiter_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int WORD_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_REQ-1:0]              up_valid,
    input  logic [N_REQ*WORD_WIDTH-1:0]   up_data,
    output logic [N_REQ-1:0]              up_ready,
    output logic                          down_valid,
    output logic [WORD_WIDTH-1:0]         down_data,
    output logic [hs_clog2(N_REQ)-1:0]    down_src,
    input  logic                          down_ready
);

    localparam int SRC_W = hs_clog2(N_REQ);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);
    localparam logic [SRC_W-1:0] LAST_REQ  = SRC_W'(N_REQ - 1);

    arb_state_e                      state, state_nx;
    logic [SRC_W-1:0]                grant_idx, grant_nx;
    logic [SRC_W-1:0]                ptr, ptr_nx;
    logic [CNT_W-1:0]                beat_cnt, cnt_nx;
    logic [SRC_W-1:0]                rr_sel;
    logic [SRC_W-1:0]                grant_inc;
    logic [N_REQ-1:0][WORD_WIDTH-1:0] up_words;
    logic                            slice_valid, slice_ready, fire;

    assign up_words    = up_data;
    assign grant_inc   = (grant_idx == LAST_REQ) ? '0 : grant_idx + 1'b1;
    assign slice_valid = (state == GRANT) && up_valid[grant_idx];
    assign fire        = slice_valid && slice_ready;

    // First valid requester at or after ptr, wrapping at N_REQ-1.
    always_comb begin
        rr_sel = ptr;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            int j;
            logic [SRC_W-1:0] cand;
            j = int'(ptr) + i;
            if (j >= N_REQ) j = j - N_REQ;
            cand = SRC_W'(j);
            if (up_valid[cand]) rr_sel = cand;
        end
    end

    // Only the granted requester sees ready, and only when the output slot can take a beat.
    always_comb begin
        up_ready = '0;
        if (state == GRANT) up_ready[grant_idx] = slice_ready;
    end

    // Next-state: grant from IDLE, release on full burst or when the owner drops valid.
    always_comb begin
        state_nx = state;
        grant_nx = grant_idx;
        ptr_nx   = ptr;
        cnt_nx   = beat_cnt;
        case (state)
            IDLE: begin
                if (|up_valid) begin
                    state_nx = GRANT;
                    grant_nx = rr_sel;
                    cnt_nx   = '0;
                end
            end
            GRANT: begin
                if (!up_valid[grant_idx] || (fire && beat_cnt == LAST_BEAT)) begin
                    state_nx = IDLE;
                    ptr_nx   = grant_inc;
                end else if (fire) begin
                    cnt_nx = beat_cnt + 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Arbiter state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            grant_idx <= '0;
            ptr       <= '0;
            beat_cnt  <= '0;
        end else begin
            state     <= state_nx;
            grant_idx <= grant_nx;
            ptr       <= ptr_nx;
            beat_cnt  <= cnt_nx;
        end
    end

    hs_reg_slice #(
        .WORD_WIDTH (WORD_WIDTH),
        .SRC_W      (SRC_W)
    ) u_out (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (slice_valid),
        .in_ready  (slice_ready),
        .in_data   (up_words[grant_idx]),
        .in_src    (grant_idx),
        .out_valid (down_valid),
        .out_data  (down_data),
        .out_src   (down_src),
        .out_ready (down_ready)
    );

endmodule

// File: tb/tb_hs_rr_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a transaction-level model.
module tb_hs_rr_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int MB = 4;
    localparam int SW = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   up_valid;
    logic [N*W-1:0] up_data;
    logic [N-1:0]   up_ready;
    logic           down_valid;
    logic [W-1:0]   down_data;
    logic [SW-1:0]  down_src;
    logic           down_ready;

    hs_rr_arbiter #(.N_REQ(N), .WORD_WIDTH(W), .MAX_BURST(MB)) dut (
        .clk        (clk),
        .rst        (rst),
        .up_valid   (up_valid),
        .up_data    (up_data),
        .up_ready   (up_ready),
        .down_valid (down_valid),
        .down_data  (down_data),
        .down_src   (down_src),
        .down_ready (down_ready)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Model: owner = -1 when nobody holds the grant; taken = beats moved in this grant.
    int          m_owner, m_start, m_taken, m_dd, m_ds;
    bit          m_dv;
    int          seq[N];
    int          cyc;
    logic [31:0] dv_mask;
    int          beats_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = -1; m_start = 0; m_taken = 0;
        m_dv = 0; m_dd = 0; m_ds = 0;
        for (int i = 0; i < N; i++) seq[i] = 0;
        cyc = 0; dv_mask = '0;
        beats_q.delete();
    endtask

    // One clock: caller has set up_valid/down_ready at the falling edge.
    task automatic cycle();
        logic [N-1:0]   er;
        logic [N*W-1:0] ud;
        bit             rdy_ok, fire;
        int             fo;
        for (int i = 0; i < N; i++) up_data[i*W +: W] = W'(i * 32 + (seq[i] & 31));
        #1;
        rdy_ok = !m_dv || down_ready;
        er = '0;
        if (m_owner >= 0 && rdy_ok) er[m_owner] = 1'b1;
        check("up_ready",   up_ready,   er);
        check("down_valid", down_valid, m_dv);
        check("down_data",  down_data,  m_dd);
        check("down_src",   down_src,   m_ds);
        if (down_valid && cyc < 32) dv_mask[cyc] = 1'b1;
        if (down_valid && down_ready) beats_q.push_back(int'(down_src));
        cyc++;
        // Output slot behaviour.
        fire = 0; fo = m_owner;
        if (m_owner >= 0) fire = up_valid[m_owner] && rdy_ok;
        ud = up_data;
        if (fire) begin
            m_dv = 1; m_dd = int'(ud[m_owner*W +: W]); m_ds = m_owner;
        end else if (down_ready) begin
            m_dv = 0;
        end
        // Grant ownership.
        if (m_owner < 0) begin
            if (|up_valid) begin
                for (int k = N - 1; k >= 0; k--)
                    if (up_valid[(m_start + k) % N]) m_owner = (m_start + k) % N;
                m_taken = 0;
            end
        end else if (!up_valid[m_owner]) begin
            m_start = (m_owner + 1) % N; m_owner = -1;
        end else if (fire) begin
            m_taken++;
            if (m_taken == MB) begin
                m_start = (m_owner + 1) % N; m_owner = -1;
            end
        end
        if (fire) seq[fo]++;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Asserts reset between clock edges so the asynchronous clear is visible immediately.
    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        check("rst_down_valid", down_valid, 0);
        check("rst_down_data",  down_data,  0);
        check("rst_down_src",   down_src,   0);
        check("rst_up_ready",   up_ready,   0);
        up_valid = '0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        rst = 1'b1; up_valid = '0; up_data = '0; down_ready = 1'b0;
        model_reset();
        @(negedge clk);
        check("init_down_valid", down_valid, 0);
        check("init_up_ready",   up_ready,   0);

        // Lone requester 2, six beats: 4-beat burst, one bubble, then 2 more.
        down_ready = 1'b1;
        do_reset();
        for (int c = 0; c < 12; c++) begin
            up_valid = (seq[2] < 6) ? 4'b0100 : 4'b0000;
            cycle();
        end
        check("a_dv_pattern", dv_mask, 32'h0000_01BC);
        check("a_beats", beats_q.size(), 6);
        for (int k = 0; k < beats_q.size(); k++) check("a_src", beats_q[k], 2);

        // Everyone requesting: bursts of 4 in order 0,1,2,3,0.
        do_reset();
        for (int c = 0; c < 30; c++) begin
            up_valid = 4'b1111; down_ready = 1'b1;
            cycle();
        end
        check("b_nbeats_ge20", beats_q.size() >= 20, 1);
        for (int k = 0; k < 20 && k < beats_q.size(); k++) check("b_order", beats_q[k], (k / 4) % 4);

        // Requester 1 with downstream stalling every other cycle.
        do_reset();
        for (int c = 0; c < 20; c++) begin
            up_valid = 4'b0010; down_ready = c[0];
            cycle();
        end
        check("c_no_loss", beats_q.size() + int'(down_valid), seq[1]);
        check("c_some_beats", seq[1] >= 4, 1);

        // Requester 3 releases after 2 beats; waiting requester 0 wins next.
        do_reset();
        down_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            up_valid = '0;
            up_valid[3] = (seq[3] < 2);
            up_valid[0] = (seq[3] >= 1);
            cycle();
        end
        check("d_nbeats_ge3", beats_q.size() >= 3, 1);
        if (beats_q.size() >= 3) begin
            check("d_src0", beats_q[0], 3);
            check("d_src1", beats_q[1], 3);
            check("d_src2", beats_q[2], 0);
        end

        // Reset in the middle of a burst, then requesters 1 and 2 compete.
        do_reset();
        for (int c = 0; c < 10; c++) begin
            up_valid = 4'b0001; down_ready = 1'b1;
            if (seq[0] < 2) cycle();
        end
        check("e_mid_burst", seq[0], 2);
        check("e_held_beat", down_valid, 1);
        do_reset();
        for (int c = 0; c < 10; c++) begin
            up_valid = 4'b0110; down_ready = 1'b1;
            cycle();
        end
        check("e_nbeats", beats_q.size() > 0, 1);
        if (beats_q.size() > 0) check("e_first_src", beats_q[0], 1);

        // Random traffic.
        do_reset();
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) up_valid[i] = ($urandom_range(0, 9) < 7);
            down_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/hs_rr_arbiter.md
HS_RR_ARBITER -- requirements
Module: hs_rr_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4: number of upstream requesters, 2..8.
REQ-002 SHALL have parameter WORD_WIDTH, default 8: data width per beat.
REQ-003 SHALL have parameter MAX_BURST, default 4: maximum beats per grant, 1..15.
REQ-004 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port up_valid, input, N_REQ: per-requester valid.
REQ-007 SHALL have port up_data, input, N_REQ*WORD_WIDTH: requester i data at bits [i*WORD_WIDTH +: WORD_WIDTH].
REQ-008 SHALL have port up_ready, output, N_REQ: per-requester ready.
REQ-009 SHALL have port down_valid, output, 1: output beat valid.
REQ-010 SHALL have port down_data, output, WORD_WIDTH: output beat data.
REQ-011 SHALL have port down_src, output, clog2(N_REQ): index of the requester that supplied the current down_data.
REQ-012 SHALL have port down_ready, input, 1: downstream accepts the beat.

Function
REQ-013 SHALL transfer a beat on a port when valid and ready are both high at a rising edge; valid-before-ready is legal.
REQ-014 SHALL run an arbiter FSM with two states, IDLE and GRANT, plus registers grant_idx, ptr (round-robin start) and beat_cnt (0..MAX_BURST-1).
REQ-015 In IDLE with any up_valid high, SHALL select the first requester with up_valid high, searching from ptr upward and wrapping at N_REQ-1; next state GRANT, grant_idx = selection, beat_cnt = 0.
REQ-016 In IDLE, all up_ready SHALL be 0.
REQ-017 In GRANT, up_ready[grant_idx] SHALL equal (!down_valid || down_ready); all other up_ready SHALL be 0.
REQ-018 In GRANT, on a transfer with beat_cnt == MAX_BURST-1, next state SHALL be IDLE and ptr = grant_idx+1 mod N_REQ.
REQ-019 In GRANT, on a transfer with beat_cnt < MAX_BURST-1, beat_cnt SHALL increment.
REQ-020 In GRANT with up_valid[grant_idx] low, next state SHALL be IDLE and ptr = grant_idx+1 mod N_REQ (early release).
REQ-021 SHALL hold the output stage as a one-entry register: on an upstream transfer, load down_data and down_src and set down_valid; otherwise, if down_ready, clear down_valid.
REQ-022 Simultaneous downstream drain and upstream load SHALL leave down_valid high with the new beat (full throughput while granted).
REQ-023 With down_valid high and down_ready low, down_data and down_src SHALL stay stable.
REQ-024 Latency SHALL be: up_valid rise in IDLE -> up_ready high on the next cycle -> beat on down_* on the cycle after the transfer edge.
REQ-025 Each grant SHALL cost exactly one IDLE bubble cycle; a requester holding valid high gets at most MAX_BURST consecutive beats.

Reset
REQ-026 While rst is high, SHALL force state IDLE, grant_idx = 0, ptr = 0, beat_cnt = 0, down_valid = 0, down_data = 0, down_src = 0, up_ready = 0.
REQ-027 Reset asserted mid-burst SHALL discard the held output beat; the first grant after release starts from requester 0.

Structure
REQ-028 SHALL place the FSM state encoding (IDLE/GRANT) and the clog2 helper in the shared handshake package.
REQ-029 SHALL implement the output register as sub-module hs_reg_slice (valid/ready, data plus source tag); arbitration SHALL live in the top module.

Verification
REQ-030 Single requester 2 valid continuously, down_ready = 1, 6 beats -> beats 0-3 back-to-back, one bubble, beats 4-5; down_src = 2 throughout.
REQ-031 All 4 requesters valid, down_ready = 1, MAX_BURST = 4 -> bursts of 4 granted in order 0,1,2,3,0; no requester starved.
REQ-032 Grant to requester 1, down_ready toggling 0/1 every cycle -> no beat lost or duplicated; down_data stable while down_ready = 0; 4 beats in 8 cycles.
REQ-033 Requester 3 drops valid after 2 beats -> IDLE next cycle; ptr = 0; a waiting requester 0 granted next.
REQ-034 rst pulsed high during the 3rd beat of a burst -> all outputs 0 immediately (asynchronous); after release, requesters 1 and 2 valid -> requester 1 granted first.
